// File: rtl/instr_fetch.sv
// instr_fetch: core0 RISC-V fetch stage. One outstanding imem request, captured word handed to decode.
// Optional misaligned-redirect trap is enabled by defining FETCH_MISALIGN_CHECK_EN.
module instr_fetch #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = {XLEN{1'b0}}
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [31:0]     instr,
  output logic [XLEN-1:0] instr_pc,
  output logic [6:0]      op,
  output logic [2:0]      func3,
  output logic [6:0]      func7,
  output logic            misalign_fault
);

`ifdef FETCH_MISALIGN_CHECK_EN
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_HOLD  = 3'd3,
    ST_FAULT = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_REQ  = 3'd1,
    ST_WAIT = 3'd2,
    ST_HOLD = 3'd3
  } state_t;
`endif

  localparam logic [31:0]     NOP_INSTR = 32'h0000_0013;
  localparam logic [XLEN-1:0] PC_STEP   = XLEN'(3'd4);

  state_t          state_r;
  state_t          state_s;
  logic [XLEN-1:0] pc_r;
  logic [XLEN-1:0] pc_s;
  logic [31:0]     instr_r;
  logic [31:0]     instr_s;
  logic [XLEN-1:0] instr_pc_r;
  logic [XLEN-1:0] instr_pc_s;
  logic            discard_r;
  logic            discard_s;
  logic            deliver_s;
  logic [XLEN-1:0] target_s;

`ifdef FETCH_MISALIGN_CHECK_EN
  logic            fault_r;
  logic            fault_s;
  logic            misalign_s;

  assign target_s   = redirect_pc;
  assign misalign_s = redirect && (redirect_pc[1:0] != 2'b00);
`else
  // Without the trap the target is simply word-aligned.
  assign target_s = {redirect_pc[XLEN-1:2], redirect_pc[1:0] & 2'b00};
`endif

  // A response is kept only if it answers the current pc and no redirect races it.
  assign deliver_s = (state_r == ST_WAIT) && imem_rvalid && !discard_r && !redirect;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Datapath registers: pc, held instruction and its pc, discard and fault flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_r       <= RESET_PC;
      instr_r    <= NOP_INSTR;
      instr_pc_r <= {XLEN{1'b0}};
      discard_r  <= 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
      fault_r    <= 1'b0;
`endif
    end else begin
      pc_r       <= pc_s;
      instr_r    <= instr_s;
      instr_pc_r <= instr_pc_s;
      discard_r  <= discard_s;
`ifdef FETCH_MISALIGN_CHECK_EN
      fault_r    <= fault_s;
`endif
    end
  end

  // Next-state and discard tracking; redirect always wins.
  always_comb begin
    state_s   = state_r;
    discard_s = discard_r;
    case (state_r)
      ST_IDLE: begin
        state_s = ST_REQ;
      end
      ST_REQ: begin
        if (imem_ready) begin
          // Request for the old pc is already accepted; its answer must be dropped.
          state_s   = ST_WAIT;
          discard_s = discard_r | redirect;
        end else begin
          state_s = ST_REQ;
        end
      end
      ST_WAIT: begin
        if (imem_rvalid) begin
          if (discard_r || redirect) begin
            state_s   = ST_REQ;
            discard_s = 1'b0;
          end else begin
            state_s = ST_HOLD;
          end
        end else if (redirect) begin
          state_s   = ST_WAIT;
          discard_s = 1'b1;
        end else begin
          state_s = ST_WAIT;
        end
      end
      ST_HOLD: begin
        if (redirect || instr_ready) begin
          state_s = ST_REQ;
        end else begin
          state_s = ST_HOLD;
        end
      end
`ifdef FETCH_MISALIGN_CHECK_EN
      ST_FAULT: begin
        if (redirect) begin
          state_s = ST_REQ;
        end else begin
          state_s = ST_FAULT;
        end
        // A request accepted before the trap may still answer here.
        if (imem_rvalid) begin
          discard_s = 1'b0;
        end else begin
          discard_s = discard_r;
        end
      end
`endif
      default: begin
        state_s   = ST_IDLE;
        discard_s = 1'b0;
      end
    endcase

`ifdef FETCH_MISALIGN_CHECK_EN
    fault_s = fault_r;
    if (misalign_s) begin
      state_s = ST_FAULT;
      fault_s = 1'b1;
    end else if (redirect) begin
      fault_s = 1'b0;
    end else begin
      fault_s = fault_r;
    end
`endif
  end

  // Datapath next values: capture on delivery, pc steps or jumps.
  always_comb begin
    instr_s    = instr_r;
    instr_pc_s = instr_pc_r;
    pc_s       = pc_r;
    if (deliver_s) begin
      instr_s    = imem_rdata;
      instr_pc_s = pc_r;
    end else begin
      instr_s    = instr_r;
      instr_pc_s = instr_pc_r;
    end
    if (redirect) begin
      pc_s = target_s;
    end else if (deliver_s) begin
      pc_s = pc_r + PC_STEP;
    end else begin
      pc_s = pc_r;
    end
  end

  // Handshake outputs decoded from the state register only.
  always_comb begin
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    case (state_r)
      ST_REQ: begin
        imem_req    = 1'b1;
        instr_valid = 1'b0;
      end
      ST_HOLD: begin
        imem_req    = 1'b0;
        instr_valid = 1'b1;
      end
      default: begin
        imem_req    = 1'b0;
        instr_valid = 1'b0;
      end
    endcase
  end

  assign imem_addr = pc_r;
  assign instr     = instr_r;
  assign instr_pc  = instr_pc_r;
  assign op        = instr_r[6:0];
  assign func3     = instr_r[14:12];
  assign func7     = instr_r[31:25];

`ifdef FETCH_MISALIGN_CHECK_EN
  assign misalign_fault = fault_r;
`else
  assign misalign_fault = 1'b0;
`endif

endmodule
